// File: rtl/mcp3002_pkg.sv
// Shared MCP3002 definitions: frame state encoding, config bit positions and word width.
// Imported by both the follower model and leader-side blocks.
package mcp3002_pkg;

    localparam int unsigned MCP3002_DATA_W = 10;

    // Position of each config bit in the order the leader shifts them after the start bit
    localparam int unsigned CFG_SGL  = 0;
    localparam int unsigned CFG_ODD  = 1;
    localparam int unsigned CFG_MSBF = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ST,
        S_CFG,
        S_NULL,
        S_MSB_OUT,
        S_LSB_OUT,
        S_TRAIL
    } state_t;

endpackage

// File: rtl/mcp3002_follower_spi_pin_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with a history flop
// producing single-cycle rise/fall strobes in the system clock domain.
module spi_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= {SYNC_STAGES{RESET_VAL}};
            hist <= RESET_VAL;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pin};
            hist <= sync[SYNC_STAGES-1];
        end
    end

    assign level = sync[SYNC_STAGES-1];
    assign rise  = level & ~hist;
    assign fall  = ~level & hist;

endmodule

// File: rtl/mcp3002_follower.sv
// Follower-side MCP3002 model: decodes leader frames from oversampled SPI pins
// and streams the selected channel word (MSB-first, optionally LSB-first tail) on Dout.
module mcp3002_follower
    import mcp3002_pkg::*;
#(
    parameter int unsigned DATA_W      = MCP3002_DATA_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              CLK_50MHz,
    input  logic              RESET,
    input  logic              CLKsample,
    input  logic              CS,
    input  logic              Din,
    output logic              Dout,
    output logic              Dout_oe,
    input  logic [DATA_W-1:0] ch0_word,
    input  logic [DATA_W-1:0] ch1_word,
    output logic              conv_valid,
    output logic              conv_sgl,
    output logic              conv_odd,
    output logic              conv_msbf,
    output logic              frame_done,
    output logic              frame_abort
);

    localparam int unsigned IDX_W = $clog2(DATA_W);

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic din_level, din_rise, din_fall;
    logic unused_sync;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk(CLK_50MHz), .reset(RESET), .pin(CLKsample),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall));

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk(CLK_50MHz), .reset(RESET), .pin(CS),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall));

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_din_sync (
        .clk(CLK_50MHz), .reset(RESET), .pin(Din),
        .level(din_level), .rise(din_rise), .fall(din_fall));

    assign unused_sync = ^{sclk_level, din_rise, din_fall};

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [DATA_W-1:0]  word, word_n, sel_word;
    logic [DATA_W:0]    diff_01, diff_10;
    logic [2:0]         cfg_q, cfg_n;
    logic [1:0]         cfg_cnt, cfg_cnt_n;
    logic               dout_q, dout_n, oe_q, oe_n;
    logic               sgl_n, odd_n, msbf_n, valid_n, done_n, abort_n;

    // Differential modes subtract one extra bit wide so a borrow marks a negative result
    assign diff_01 = {1'b0, ch0_word} - {1'b0, ch1_word};
    assign diff_10 = {1'b0, ch1_word} - {1'b0, ch0_word};

    always_comb begin
        sel_word = '0;
        if (cfg_q[CFG_SGL])
            sel_word = cfg_q[CFG_ODD] ? ch1_word : ch0_word;
        else if (cfg_q[CFG_ODD])
            sel_word = diff_10[DATA_W] ? '0 : diff_10[DATA_W-1:0];
        else
            sel_word = diff_01[DATA_W] ? '0 : diff_01[DATA_W-1:0];
    end

    always_ff @(posedge CLK_50MHz) begin
        if (RESET) begin
            state       <= S_IDLE;
            idx         <= '0;
            word        <= '0;
            cfg_q       <= '0;
            cfg_cnt     <= '0;
            dout_q      <= 1'b0;
            oe_q        <= 1'b0;
            conv_sgl    <= 1'b0;
            conv_odd    <= 1'b0;
            conv_msbf   <= 1'b0;
            conv_valid  <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            word        <= word_n;
            cfg_q       <= cfg_n;
            cfg_cnt     <= cfg_cnt_n;
            dout_q      <= dout_n;
            oe_q        <= oe_n;
            conv_sgl    <= sgl_n;
            conv_odd    <= odd_n;
            conv_msbf   <= msbf_n;
            conv_valid  <= valid_n;
            frame_done  <= done_n;
            frame_abort <= abort_n;
        end
    end

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        word_n    = word;
        cfg_n     = cfg_q;
        cfg_cnt_n = cfg_cnt;
        dout_n    = dout_q;
        oe_n      = oe_q;
        sgl_n     = conv_sgl;
        odd_n     = conv_odd;
        msbf_n    = conv_msbf;
        valid_n   = 1'b0;
        done_n    = 1'b0;
        abort_n   = 1'b0;

        if (cs_level) begin
            state_n = S_IDLE;
            oe_n    = 1'b0;
            dout_n  = 1'b0;
            if (cs_rise) begin
                done_n  = (state == S_TRAIL);
                abort_n = (state inside {S_CFG, S_NULL, S_MSB_OUT, S_LSB_OUT});
            end
        end else begin
            case (state)
                S_IDLE: if (cs_fall) begin
                    state_n = S_WAIT_ST;
                    oe_n    = 1'b1;
                    dout_n  = 1'b0;
                end
                S_WAIT_ST: if (sclk_rise && din_level) begin
                    state_n   = S_CFG;
                    cfg_cnt_n = '0;
                end
                S_CFG: if (sclk_rise) begin
                    cfg_n[cfg_cnt] = din_level;
                    cfg_cnt_n      = cfg_cnt + 2'd1;
                    if (cfg_cnt == 2'(CFG_MSBF)) begin
                        word_n  = sel_word;
                        sgl_n   = cfg_q[CFG_SGL];
                        odd_n   = cfg_q[CFG_ODD];
                        msbf_n  = din_level;
                        valid_n = 1'b1;
                        state_n = S_NULL;
                    end
                end
                S_NULL: if (sclk_fall) begin
                    dout_n  = 1'b0;
                    idx_n   = IDX_W'(DATA_W - 1);
                    state_n = S_MSB_OUT;
                end
                S_MSB_OUT: if (sclk_fall) begin
                    dout_n = word[idx];
                    if (idx == '0) begin
                        state_n = conv_msbf ? S_TRAIL : S_LSB_OUT;
                        idx_n   = IDX_W'(1);
                    end else begin
                        idx_n = idx - IDX_W'(1);
                    end
                end
                S_LSB_OUT: if (sclk_fall) begin
                    dout_n = word[idx];
                    if (idx == IDX_W'(DATA_W - 1))
                        state_n = S_TRAIL;
                    else
                        idx_n = idx + IDX_W'(1);
                end
                S_TRAIL: if (sclk_fall) dout_n = 1'b0;
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Tristate releases combinationally on the synced CS level so it drops with cs_rise
    assign Dout    = dout_q;
    assign Dout_oe = oe_q & ~cs_level;

endmodule

// File: tb/tb_mcp3002_follower.sv
// Directed self-checking bench for mcp3002_follower: frames driven by a
// behavioural SPI leader, Dout sampled just before each SCLK rising edge.
module tb_mcp3002_follower;

    localparam int unsigned HALF = 160;

    logic       clk, reset, sclk, cs, din, dout, dout_oe;
    logic [9:0] ch0, ch1;
    logic       conv_valid, conv_sgl, conv_odd, conv_msbf, frame_done, frame_abort;

    int unsigned errors = 0, checks = 0;
    int unsigned n_valid = 0, n_done = 0, n_abort = 0;
    int unsigned b_valid, b_done, b_abort;
    logic [31:0] bits;

    mcp3002_follower #(.DATA_W(10), .SYNC_STAGES(2)) dut (
        .CLK_50MHz(clk), .RESET(reset), .CLKsample(sclk), .CS(cs), .Din(din),
        .Dout(dout), .Dout_oe(dout_oe), .ch0_word(ch0), .ch1_word(ch1),
        .conv_valid(conv_valid), .conv_sgl(conv_sgl), .conv_odd(conv_odd),
        .conv_msbf(conv_msbf), .frame_done(frame_done), .frame_abort(frame_abort));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (conv_valid)  n_valid++;
        if (frame_done)  n_done++;
        if (frame_abort) n_abort++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sclk_cycle(input logic d, output logic s);
        din = d;
        #(HALF);
        s = dout;
        sclk = 1'b1;
        #(HALF);
        sclk = 1'b0;
    endtask

    // Start bit, SGL, ODD, MSBF, then nsamp captured Dout bits (first is the null bit)
    task automatic run_frame(input int zeros, input logic sgl, input logic odd, input logic msbf,
                             input int nsamp, input logic chg, input logic [9:0] chg_val,
                             output logic [31:0] captured);
        logic s;
        @(negedge clk);
        #3;
        cs = 1'b0;
        #(HALF);
        for (int i = 0; i < zeros; i++) sclk_cycle(1'b0, s);
        sclk_cycle(1'b1, s);
        sclk_cycle(sgl, s);
        sclk_cycle(odd, s);
        sclk_cycle(msbf, s);
        if (chg) ch0 = chg_val;
        captured = '0;
        for (int i = 0; i < nsamp; i++) begin
            sclk_cycle(1'b0, s);
            captured = {captured[30:0], s};
        end
    endtask

    task automatic cs_up();
        #(HALF);
        cs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic mark();
        b_valid = n_valid;
        b_done  = n_done;
        b_abort = n_abort;
    endtask

    initial begin
        reset = 1'b1; sclk = 1'b0; cs = 1'b1; din = 1'b0; ch0 = '0; ch1 = '0;
        repeat (3) @(negedge clk);
        check("rst_dout", 32'(dout), 0);
        check("rst_oe", 32'(dout_oe), 0);
        check("rst_conv", 32'({conv_valid, conv_sgl, conv_odd, conv_msbf}), 0);
        check("rst_pulses", 32'({frame_done, frame_abort}), 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // 1: single-ended CH0, MSB-first only, two trailing zeros
        ch0 = 10'h2A5; ch1 = 10'h0F0;
        mark();
        run_frame(0, 1'b1, 1'b0, 1'b1, 13, 1'b0, '0, bits);
        check("t1_bits", bits, {1'b0, 10'h2A5, 2'b00});
        check("t1_valid", n_valid - b_valid, 1);
        check("t1_conv", 32'({conv_sgl, conv_odd, conv_msbf}), 3'b101);
        check("t1_oe_on", 32'(dout_oe), 1);
        cs_up();
        check("t1_done", n_done - b_done, 1);
        check("t1_abort", n_abort - b_abort, 0);
        check("t1_oe_off", 32'(dout_oe), 0);

        // 2: single-ended CH1, LSB-first tail B1..B9 of 0x301 = 000000011
        ch1 = 10'h301;
        mark();
        run_frame(0, 1'b1, 1'b1, 1'b0, 21, 1'b0, '0, bits);
        check("t2_bits", bits, {1'b0, 10'h301, 9'b000000011, 1'b0});
        check("t2_conv", 32'({conv_sgl, conv_odd, conv_msbf}), 3'b110);
        cs_up();
        check("t2_done", n_done - b_done, 1);

        // 3: differential, 500-200 = 300; 100-400 clamps to 0; ODD=1 gives ch1-ch0
        ch0 = 10'd500; ch1 = 10'd200;
        run_frame(0, 1'b0, 1'b0, 1'b1, 12, 1'b0, '0, bits);
        check("t3_diff", bits, {1'b0, 10'd300, 1'b0});
        check("t3_conv", 32'({conv_sgl, conv_odd, conv_msbf}), 3'b001);
        cs_up();
        ch0 = 10'd100; ch1 = 10'd400;
        run_frame(0, 1'b0, 1'b0, 1'b1, 12, 1'b0, '0, bits);
        check("t3_clamp", bits, 0);
        cs_up();
        run_frame(0, 1'b0, 1'b1, 1'b1, 12, 1'b0, '0, bits);
        check("t3_odd", bits, {1'b0, 10'd300, 1'b0});
        check("t3_conv_odd", 32'({conv_sgl, conv_odd, conv_msbf}), 3'b011);
        cs_up();

        // 4: two leading zeros, then an aborted frame after four data bits
        ch0 = 10'h155;
        run_frame(2, 1'b1, 1'b0, 1'b1, 12, 1'b0, '0, bits);
        check("t4_lead0", bits, {1'b0, 10'h155, 1'b0});
        cs_up();
        mark();
        run_frame(0, 1'b1, 1'b0, 1'b1, 5, 1'b0, '0, bits);
        check("t4_part", bits, {1'b0, 4'b0101});
        cs = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t4_oe_off", 32'(dout_oe), 0);
        repeat (8) @(negedge clk);
        check("t4_abort", n_abort - b_abort, 1);
        check("t4_done", n_done - b_done, 0);

        // 5: channel input changes after latch must not disturb the stream
        ch0 = 10'h3FF;
        run_frame(0, 1'b1, 1'b0, 1'b1, 12, 1'b1, 10'h000, bits);
        check("t5_frozen", bits, {1'b0, 10'h3FF, 1'b0});
        cs_up();

        // 6: reset in the middle of MSB_OUT
        ch0 = 10'h2A5;
        mark();
        run_frame(0, 1'b1, 1'b0, 1'b1, 5, 1'b0, '0, bits);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t6_rst_out", 32'({dout, dout_oe}), 0);
        check("t6_rst_conv", 32'({conv_valid, conv_sgl, conv_odd, conv_msbf}), 0);
        check("t6_rst_pulse", 32'({frame_done, frame_abort}), 0);
        @(negedge clk);
        reset = 1'b0;
        cs_up();
        check("t6_no_pulse", (n_done - b_done) + (n_abort - b_abort), 0);
        ch1 = 10'h2C3;
        run_frame(0, 1'b1, 1'b1, 1'b1, 12, 1'b0, '0, bits);
        check("t6_after", bits, {1'b0, 10'h2C3, 1'b0});
        check("t6_conv", 32'({conv_sgl, conv_odd, conv_msbf}), 3'b111);
        cs_up();
        check("t6_done", n_done - b_done, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
